// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display driver: canonical
// active-high segment patterns {a,b,c,d,e,f,g}, FSM state encoding and
// small arithmetic helpers used by the conversion engine.
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // 10^n as a 32-bit constant; used to build the overflow threshold.
    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] acc;
        acc = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 32'd10;
        end
        return acc;
    endfunction

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before shifting.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Single-digit encoder: BCD nibble plus blank/dash overrides to a 7-segment
// pattern. Dash wins over blank; nibbles above 9 cannot occur in normal
// operation and are shown as a dash. active_low inverts the pattern so a
// lit segment is driven 0.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    input  logic       active_low,
    output logic [6:0] seg
);

    logic [6:0] pat_s;

    // Select the active-high pattern, then apply panel polarity.
    always_comb begin
        pat_s = SEG_BLANK;
        if (dash) begin
            pat_s = SEG_DASH;
        end else if (blank) begin
            pat_s = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    pat_s = SEG_0;
                4'd1:    pat_s = SEG_1;
                4'd2:    pat_s = SEG_2;
                4'd3:    pat_s = SEG_3;
                4'd4:    pat_s = SEG_4;
                4'd5:    pat_s = SEG_5;
                4'd6:    pat_s = SEG_6;
                4'd7:    pat_s = SEG_7;
                4'd8:    pat_s = SEG_8;
                4'd9:    pat_s = SEG_9;
                default: pat_s = SEG_DASH;
            endcase
        end
        if (active_low) begin
            seg = ~pat_s;
        end else begin
            seg = pat_s;
        end
    end

endmodule

// File: rtl/seg7_bin_display.sv
// Sign-magnitude binary to multi-digit seven-segment driver. A start pulse
// in IDLE loads the value; an iterative shift-add-3 engine then produces BCD
// over IN_W cycles and the display registers update together with a
// one-cycle done pulse. Define LZ_BLANK_EN to blank leading zero digits
// (digit 0 is always shown; overflow dashes take precedence).
module seg7_bin_display
    import seg7_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int DIGITS     = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W:0]         in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*7-1:0]   seg,
    output logic                  minus,
    output logic                  ovf
);

    localparam int               BCD_W    = DIGITS * 4;
    localparam int               CNT_W    = $clog2(IN_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [31:0]      LIMIT    = pow10(DIGITS);
    localparam logic             POL_LOW  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic             LIT_ON   = ~POL_LOW;
    localparam logic [6:0]       BLANK_CODE = POL_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_t                   state_r;
    state_t                   state_nx_s;
    logic                     load_s;
    logic                     shift_en_s;
    logic                     finish_s;

    logic [IN_W-1:0]          shift_r;
    logic [BCD_W-1:0]         bcd_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     sign_r;
    logic                     nz_r;
    logic                     ovf_nx_r;

    logic [BCD_W-1:0]         bcd_adj_s;
    logic [BCD_W+IN_W-1:0]    cat_s;
    logic [BCD_W-1:0]         bcd_sh_s;
    logic [IN_W-1:0]          shift_sh_s;
    logic [DIGITS-1:0]        blank_s;
    logic [DIGITS*7-1:0]      enc_seg_s;

    logic                     busy_r;
    logic                     done_r;
    logic [DIGITS*7-1:0]      seg_r;
    logic                     minus_r;
    logic                     ovf_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: IDLE waits for start, SHIFT runs IN_W steps.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM control outputs: load, shift enable and final-step strobe.
    always_comb begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = start;
            end
            ST_SHIFT: begin
                shift_en_s = 1'b1;
                finish_s   = (cnt_r == LAST_CNT);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // One double-dabble step: correct each nibble, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            bcd_adj_s[k*4 +: 4] = dabble_adj(bcd_r[k*4 +: 4]);
        end
        cat_s      = {bcd_adj_s, shift_r} << 1;
        bcd_sh_s   = cat_s[BCD_W+IN_W-1:IN_W];
        shift_sh_s = cat_s[IN_W-1:0];
    end

    // Conversion datapath: load on start, step while shifting, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r  <= '0;
            bcd_r    <= '0;
            cnt_r    <= '0;
            sign_r   <= 1'b0;
            nz_r     <= 1'b0;
            ovf_nx_r <= 1'b0;
        end else if (load_s) begin
            shift_r  <= in[IN_W-1:0];
            bcd_r    <= '0;
            cnt_r    <= '0;
            sign_r   <= in[IN_W];
            nz_r     <= |in[IN_W-1:0];
            ovf_nx_r <= (32'(in[IN_W-1:0]) >= LIMIT);
        end else if (shift_en_s) begin
            shift_r  <= shift_sh_s;
            bcd_r    <= bcd_sh_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            shift_r  <= shift_r;
            bcd_r    <= bcd_r;
            cnt_r    <= cnt_r;
        end
    end

    // Leading-zero blanking mask for the BCD result being registered.
    always_comb begin
`ifdef LZ_BLANK_EN
        logic lead;
        blank_s = '0;
        lead    = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (bcd_sh_s[k*4 +: 4] == 4'd0)) begin
                blank_s[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
`else
        blank_s = '0;
`endif
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_digit_enc u_enc (
            .nibble     (bcd_sh_s[k*4 +: 4]),
            .blank      (blank_s[k]),
            .dash       (ovf_nx_r),
            .active_low (POL_LOW),
            .seg        (enc_seg_s[k*7 +: 7])
        );
    end

    // Output registers: status every cycle, display only on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            seg_r   <= {DIGITS{BLANK_CODE}};
            minus_r <= ~LIT_ON;
            ovf_r   <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_SHIFT);
            done_r <= finish_s;
            if (finish_s) begin
                seg_r   <= enc_seg_s;
                ovf_r   <= ovf_nx_r;
                minus_r <= (sign_r && nz_r) ? LIT_ON : ~LIT_ON;
            end else begin
                seg_r   <= seg_r;
                ovf_r   <= ovf_r;
                minus_r <= minus_r;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign seg   = seg_r;
    assign minus = minus_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_seg7_bin_display.sv
// Scoreboard bench for seg7_bin_display: expected display values are pushed
// when a start is driven and compared when done pulses. DUT a uses the
// default parameters, DUT b uses IN_W=10 to reach overflow.
module tb_seg7_bin_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [8:0]  in_a;
    logic [10:0] in_b;
    logic        busy_a, done_a, minus_a, ovf_a;
    logic        busy_b, done_b, minus_b, ovf_b;
    logic [20:0] seg_a, seg_b;

    typedef struct packed {
        logic [20:0] seg;
        logic        minus;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_a_cnt = 0;
    int   done_b_cnt = 0;

    always #5 clk = ~clk;

    seg7_bin_display u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in(in_a),
        .busy(busy_a), .done(done_a), .seg(seg_a), .minus(minus_a), .ovf(ovf_a)
    );

    seg7_bin_display #(.IN_W(10), .DIGITS(3), .ACTIVE_LOW(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in(in_b),
        .busy(busy_b), .done(done_b), .seg(seg_b), .minus(minus_b), .ovf(ovf_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    // Reference display for a 3-digit active-low panel.
    function automatic exp_t model(input int mag, input bit sign);
        exp_t       e;
        int         p;
        logic [6:0] pat;
        e.ovf   = (mag >= 1000);
        e.minus = !(sign && (mag != 0));
        e.seg   = '0;
        p = 1;
        for (int k = 0; k < 3; k++) begin
            if (e.ovf) begin
                pat = 7'b0000001;
            end else begin
                pat = ref_pat((mag / p) % 10);
`ifdef LZ_BLANK_EN
                if (k > 0 && mag < p) pat = 7'b0000000;
`endif
            end
            e.seg[k*7 +: 7] = ~pat;
            p = p * 10;
        end
        return e;
    endfunction

    // Scoreboard compare for DUT a on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done_a === 1'b1) begin
            done_a_cnt++;
            if (q_a.size() == 0) begin
                check_eq("a_unexpected_done", q_a.size(), 1);
            end else begin
                e = q_a.pop_front();
                check_eq("a_seg",   seg_a,   e.seg);
                check_eq("a_minus", minus_a, e.minus);
                check_eq("a_ovf",   ovf_a,   e.ovf);
            end
        end
    end

    // Scoreboard compare for DUT b on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done_b === 1'b1) begin
            done_b_cnt++;
            if (q_b.size() == 0) begin
                check_eq("b_unexpected_done", q_b.size(), 1);
            end else begin
                e = q_b.pop_front();
                check_eq("b_seg",   seg_b,   e.seg);
                check_eq("b_minus", minus_b, e.minus);
                check_eq("b_ovf",   ovf_b,   e.ovf);
            end
        end
    end

    // Full conversion on DUT a with cycle-exact busy/done checks.
    task automatic conv_a(input logic [8:0] v);
        @(posedge clk); #1;
        in_a    = v;
        start_a = 1'b1;
        q_a.push_back(model(int'(v[7:0]), v[8]));
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_eq("a_busy", busy_a, (i < 9) ? 1 : 0);
            check_eq("a_done", done_a, (i == 9) ? 1 : 0);
        end
    endtask

    // Conversion on DUT b; done must arrive exactly 11 cycles after start.
    task automatic conv_b(input logic [10:0] v);
        int c;
        @(posedge clk); #1;
        in_b    = v;
        start_b = 1'b1;
        q_b.push_back(model(int'(v[9:0]), v[10]));
        @(posedge clk); #1;
        start_b = 1'b0;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_b === 1'b1) break;
        end
        check_eq("b_latency", c, 11);
    endtask

    initial begin
        int   c;
        int   cnt0;
        exp_t last;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        in_a    = '0;
        in_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  busy_a,  0);
        check_eq("rst_done",  done_a,  0);
        check_eq("rst_ovf",   ovf_a,   0);
        check_eq("rst_minus", minus_a, 1);
        check_eq("rst_seg",   seg_a,   21'h1FFFFF);
        check_eq("rst_b_seg", seg_b,   21'h1FFFFF);
        rst_n = 1'b1;

        conv_a(9'h0FF);
        conv_a(9'h107);
        conv_a(9'h100);
        conv_a(9'h000);
        conv_a(9'h080);
        conv_a(9'h1F5);
        for (int i = 0; i < 4; i++) begin
            conv_a(9'($urandom_range(0, 511)));
        end

        // Outputs hold between conversions.
        conv_a(9'h10C);
        last = model(12, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_seg",   seg_a,   last.seg);
        check_eq("hold_minus", minus_a, last.minus);

        // A start while busy is ignored.
        cnt0 = done_a_cnt;
        @(posedge clk); #1;
        in_a = 9'd123; start_a = 1'b1;
        q_a.push_back(model(123, 1'b0));
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_a = 9'd45; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_eq("busy_start_ignored", done_a_cnt - cnt0, 1);

        // A start in the done cycle is accepted; second done 9 cycles later.
        conv_a(9'd200);
        in_a = 9'h163; start_a = 1'b1;
        q_a.push_back(model(99, 1'b1));
        @(posedge clk); #1;
        start_a = 1'b0;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_a === 1'b1) break;
        end
        check_eq("done_cycle_restart", c, 9);

        // Reset in the middle of a conversion aborts it.
        @(posedge clk); #1;
        in_a = 9'd77; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cnt0  = done_a_cnt;
        @(posedge clk); #1;
        check_eq("midrst_busy",  busy_a,  0);
        check_eq("midrst_done",  done_a,  0);
        check_eq("midrst_seg",   seg_a,   21'h1FFFFF);
        check_eq("midrst_minus", minus_a, 1);
        check_eq("midrst_ovf",   ovf_a,   0);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("midrst_no_done", done_a_cnt - cnt0, 0);
        conv_a(9'h0FF);

        // Overflow boundary on the 10-bit instance.
        conv_b(11'd1000);
        conv_b(11'd999);
        conv_b(11'd1023);
        conv_b(11'h400);
        conv_b(11'h7E8);
        conv_b(11'h409);

        repeat (3) @(posedge clk);
        #1;
        check_eq("a_queue_empty", q_a.size(), 0);
        check_eq("b_queue_empty", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_bin_display.md
# seg7_bin_display

Sequential binary-to-seven-segment display driver: accepts a signed-magnitude binary value, converts it to BCD with an iterative shift-add-3 (double-dabble) engine, and drives a parametrised number of 7-segment digits plus a minus indicator. It is the parametrised successor of the team's fixed 3-digit, 8-bit display decoder. It sits between the remote-control value logic and the board's segment pins, and it adds a start/busy/done handshake, overflow indication and selectable segment polarity.

## Interface
- IN_W, 8, magnitude width in bits (2..16)
- DIGITS, 3, number of displayed decimal digits (1..5)
- ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request conversion of `in`; sampled only in IDLE
- in  in  IN_W+1  bit IN_W = sign (1 = negative), bits IN_W-1:0 = magnitude
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; `seg`/`minus`/`ovf` updated this cycle
- seg  out  DIGITS*7  digit k at bits 7k+6:7k, order {a,b,c,d,e,f,g}, a at MSB; digit 0 = units
- minus  out  1  minus indicator, polarity per ACTIVE_LOW
- ovf  out  1  magnitude ≥ 10^DIGITS for the last conversion

## Operation
- FSM: IDLE, SHIFT. Reset → IDLE.
- IDLE: start=1 latches magnitude into shift reg, sign into sign reg, clears BCD reg (DIGITS*4 bits) and counter; computes ovf_next = (magnitude ≥ 10^DIGITS) from a parameter constant; → SHIFT.
- SHIFT: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, shift} shifts left 1. Counter counts 0..IN_W-1; after the IN_W-th shift → IDLE and registers outputs.
- Output register update (single edge, with done=1): seg from BCD via digit encoder; ovf=ovf_next; minus lit iff sign=1 and magnitude≠0 (no −0).
- Overflow: all digits show dash (g only); minus still follows the sign rule.
- start while busy ignored (no queueing). start in the done cycle is accepted (FSM in IDLE).
- Outputs hold between conversions.
- Reset values: busy 0, done 0, ovf 0, minus unlit, every seg digit blank (all segments unlit: all 1 when ACTIVE_LOW=1).
- Reset mid-conversion: aborts; no done pulse; outputs return to reset values.

## Timing
- start=1 sampled at edge of cycle 0 → busy=1 in cycles 1..IN_W → done=1 and new seg/minus/ovf in cycle IN_W+1; busy=0 in that cycle.
- Throughput: one conversion per IN_W+1 cycles with back-to-back start.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- LZ_BLANK_EN defined: leading zero digits blanked, digit 0 always shown; a value of 0 shows a single "0". Ignored when ovf=1.
- LZ_BLANK_EN undefined: every digit shown, including leading zeros.

## Structure
- Package seg7_pkg: active-high canonical patterns SEG_0..SEG_9 (SEG_0 = 1111110, SEG_8 = 1111111), SEG_DASH = 0000001, SEG_BLANK = 0000000; state enum for IDLE/SHIFT.
- Sub-module seg7_digit_enc: combinational 4-bit nibble + blank + dash + polarity → 7 segments. Instantiated DIGITS times. Nibbles > 9 are unreachable and map to SEG_DASH.

## Test plan
Defaults (IN_W=8, DIGITS=3, ACTIVE_LOW=1) unless stated.
- in=9'h0FF, start pulse → done in cycle 9; digits 2,1,0 = 0010010, 0100100, 0100100; minus=1; ovf=0.
- in=9'h107 → minus=0 (lit); LZ_BLANK_EN: digits 2,1 = 1111111, digit 0 = 0001111; without the macro: 0000001, 0000001, 0001111.
- in=9'h100 (−0) → minus=1 (unlit); digit 0 = 0000001.
- IN_W=10, in=11'd1000 → ovf=1, all three digits = 1111110; in=11'd999 → ovf=0, digits 0000100 ×3.
- start at cycle 3 of a conversion is ignored (single done); start in the done cycle → second done exactly 9 cycles later.
- rst_n=0 in cycle 4 of a conversion → busy=0 and seg all ones next cycle; no done pulse.
